apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares one APB slave port (8-bit address, 16-bit data) between two internal requesters.
- Arbitrates round-robin and sequences the IDLE/SETUP/ACCESS protocol.
- Returns read data or a timeout error to the winning requester.
- Sits between the register-access clients and the APB slave memory.

Parameters:
- TIMEOUT, 16, max ACCESS cycles to wait for pready (1..255); 0 disables the timeout.

Ports:
- pclk  input  1  APB clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester transfer request; bit i = requester i
- req_ready  output  2  per-requester grant/accept strobe (combinational, IDLE only)
- req0_addr  input  8  requester 0 address
- req0_wdata  input  16  requester 0 write data
- req0_write  input  1  requester 0 direction; 1 = write
- req1_addr  input  8  requester 1 address
- req1_wdata  input  16  requester 1 write data
- req1_write  input  1  requester 1 direction; 1 = write
- rsp_valid  output  2  one-cycle completion pulse to requester i
- rsp_rdata  output  16  read data for the completing transfer; 0 for writes
- rsp_err  output  1  completion was a timeout; qualified by rsp_valid
- psel  output  1  APB select
- penable  output  1  APB enable
- paddr  output  8  APB address
- pwrite  output  1  APB direction
- pwdata  output  16  APB write data
- prdata  input  16  APB read data
- pready  input  1  APB ready

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; psel, penable, pwrite=0; paddr, pwdata=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; timeout count=0; priority pointer=requester 0. req_ready=0 while rst_n low.
- States, one-hot: IDLE, SETUP, ACCESS.
- IDLE arbitration:
  - Winner is the valid requester if only one is valid.
  - If both are valid, the winner is the one holding priority.
  - req_ready[winner]=1 combinationally in that cycle only.
  - On that edge: capture the winner's addr/wdata/write into paddr/pwdata/pwrite, record the winner index, move priority to the other requester, go to SETUP.
  - With no req_valid, stay in IDLE; psel=0, penable=0.
- SETUP: psel=1, penable=0, APB fields stable. Always goes to ACCESS on the next edge; the timeout count clears.
- ACCESS: psel=1, penable=1.
  - pready=1 at an edge completes the transfer normally.
  - pready=0 increments the count.
  - When TIMEOUT≠0 and the count reaches TIMEOUT with pready still 0, the transfer completes with error.
  - Either completion goes to IDLE.
- Completion (registered, visible in the first IDLE cycle after ACCESS):
  - rsp_valid[winner]=1 for exactly one cycle.
  - rsp_rdata = prdata sampled at the completing edge for normal reads; 0 for writes and for timeouts.
  - rsp_err=1 only on timeout.
  - rsp_rdata and rsp_err hold until the next completion.
- Latency with pready tied 1:
  - Accept edge, then SETUP cycle, then ACCESS cycle, then rsp_valid in the following cycle.
  - One transfer every 3 cycles.
  - A new grant is allowed in the same cycle rsp_valid is high.
- psel always drops for at least one cycle (IDLE) between transfers; there are no back-to-back SETUPs.
- Requester rules:
  - Request fields need only be valid in the accept cycle.
  - Dropping req_valid before acceptance cancels the request with no side effects.
  - A requester keeping req_valid high is re-arbitrated at the next IDLE.
- Simultaneous requests: the priority pointer guarantees strict alternation under continuous contention.
- Reset mid-transfer: the APB signals drop immediately and no rsp_valid is issued for the aborted transfer.
- APB outputs paddr, pwdata and pwrite are registered and change only on accept edges.

Test Plan:
- Reset, then req_valid=01 with req0 write addr 0x12 data 0xBEEF, pready=1:
  - req_ready=01 for 1 cycle.
  - psel=1/penable=0, then 1/1, with paddr=0x12, pwdata=0xBEEF, pwrite=1.
  - rsp_valid=01, rsp_err=0, rsp_rdata=0.
- req1 read addr 0x12, bench slave returns prdata=0xBEEF with pready=1: rsp_valid=10, rsp_rdata=0xBEEF, 3 cycles after accept.
- Both requesters valid continuously for 6 transfers from reset:
  - Grants go 0,1,0,1,0,1.
  - psel low exactly one cycle between transfers.
- pready held 0 for 3 ACCESS cycles, then 1: penable stays high for 4 cycles, normal completion with rsp_err=0.
- TIMEOUT=16, pready stuck 0:
  - penable drops after 16 ACCESS cycles.
  - rsp_valid pulses with rsp_err=1, rsp_rdata=0.
  - The next grant proceeds normally.
- rst_n asserted low during ACCESS:
  - psel/penable go 0 asynchronously.
  - No rsp_valid is issued.
  - After release, the first grant goes to requester 0 when both request.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester-side handshake signals and the APB master bus.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req0_write;
    logic [7:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        req1_write;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;

    modport master (
        input  req_valid, req0_addr, req0_wdata, req0_write,
               req1_addr, req1_wdata, req1_write, prdata, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output req_valid, req0_addr, req0_wdata, req0_write,
               req1_addr, req1_wdata, req1_write, prdata, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, paddr, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: arbitrates in IDLE, runs SETUP/ACCESS,
// and returns read data or a timeout error to the requester that won.
module apb_master_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                 pclk,
    input logic                 rst_n,
    apb_master_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_SETUP  = 3'b010,
        S_ACCESS = 3'b100
    } state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_winner;
    logic [7:0]  r_paddr;
    logic [15:0] r_pwdata;
    logic        r_pwrite;
    logic [7:0]  r_cnt;
    logic [1:0]  r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_win;
    logic        w_grant;
    logic        w_done_ok;
    logic        w_done_to;
    logic [8:0]  w_cnt_inc;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        w_grant       = 1'b0;
        w_done_ok     = 1'b0;
        w_done_to     = 1'b0;
        w_win         = (&bus.req_valid) ? r_prio : bus.req_valid[1];
        w_cnt_inc     = {1'b0, r_cnt} + 9'd1;
        case (r_state)
            S_IDLE: begin
                // rst_n gates the grant so req_ready stays low throughout reset
                if (rst_n && (|bus.req_valid)) begin
                    w_grant              = 1'b1;
                    bus.req_ready[w_win] = 1'b1;
                    w_state_nxt          = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    w_done_ok = 1'b1;
                end else if ((TIMEOUT != 0) && (w_cnt_inc == TO_LIM)) begin
                    w_done_to = 1'b1;
                end
                if (w_done_ok || w_done_to) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio      <= 1'b0;
            r_winner    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_grant) begin
                r_paddr  <= w_win ? bus.req1_addr  : bus.req0_addr;
                r_pwdata <= w_win ? bus.req1_wdata : bus.req0_wdata;
                r_pwrite <= w_win ? bus.req1_write : bus.req0_write;
                r_winner <= w_win;
                r_prio   <= ~w_win;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !bus.pready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_done_ok || w_done_to) begin
                r_rsp_valid[r_winner] <= 1'b1;
                r_rsp_err             <= w_done_to;
                r_rsp_rdata           <= (w_done_ok && !r_pwrite) ? bus.prdata : 16'h0000;
            end
        end
    end

    assign bus.psel      = (r_state != S_IDLE);
    assign bus.penable   = (r_state == S_ACCESS);
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pwrite    = r_pwrite;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
